pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined ripple-carry adder/subtractor; generalises the fixed 4-bit ripple-carry adder to WIDTH bits.

- Splits the carry chain into CHUNK-bit slices, one slice per pipeline stage.
- Sustains one operation per clock under a valid/ready handshake.
- Reports carry/borrow and signed overflow.
- Serves as the arithmetic building block for the datapath's accumulators and address generators.

## Interface
- WIDTH, 16: operand/result width in bits.
- CHUNK, 4: bits resolved per pipeline stage. WIDTH % CHUNK must be 0. STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  result.
- cout  output  1  carry-out; in sub mode 1 = no borrow, 0 = borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Accept when in_valid && in_ready. Stage 0 captures a and b_eff = sub ? ~b : b, plus c0 = sub ? ~cin : cin.
- Stage k (0..STAGES−1) adds slice [k·CHUNK +: CHUNK] of a and b_eff with the incoming carry.
  - Registers the sum slice and the carry.
  - Forwards the not-yet-processed upper slices.
  - Forwards the already-resolved lower sum slices.
- Last stage computes:
  - cout = final carry.
  - ovf = carry into MSB XOR final carry.
- Each stage holds a valid bit. A bubble (invalid stage) holds no data obligation and is overwritten freely.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
  - adv=1: every stage shifts forward by one; stage 0 loads the new op or a bubble.
  - adv=0: all stages hold; s/cout/ovf stay stable while out_valid=1.
- Results emerge in acceptance order. No drop, no duplication.
- Arithmetic is modulo 2^WIDTH. cin and sub are sampled per operation, so add/sub operations may be mixed freely.

## Timing
- Latency: an operation accepted at edge N presents out_valid=1 after edge N+STAGES when no stall occurs.
- Throughput: 1 op/cycle with out_ready held high.
- Stall: each cycle with out_valid=1 && out_ready=0 adds one cycle of latency to every in-flight op.
- in_ready is a combinational function of out_valid and out_ready. There is no path from in_valid to in_ready.
- Simultaneous output handshake and input accept in the same cycle: both occur and the pipeline stays full.
- Reset, which applies immediately and asynchronously:
  - All valid bits clear, so out_valid=0.
  - s=0, cout=0, ovf=0.
  - In-flight ops are discarded.
  - in_ready=1 while rst=0 and the pipeline is empty.
  - The first op accepted after release behaves as from power-up.
- Reset mid-stall: the pending output is discarded and no stale result appears after release.

## Configuration
- ADDSUB_SAT_EN defined: signed saturation at the last stage.
  - If ovf=1, s = 0x7FF…F when a[MSB]=0, and s = 0x80…0 when a[MSB]=1.
  - ovf still reports 1. cout is unchanged.
- ADDSUB_SAT_EN undefined: s wraps modulo 2^WIDTH. ovf is still reported.
- Latency and handshake are identical in both builds.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, so latency is 4.
- Add: a=0x00FF, b=0x0001, cin=0, sub=0 → 4 cycles later out_valid=1, s=0x0100, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 → s=0x0000, cout=1, ovf=0.
- Overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 → ovf=1, cout=0.
  - Without ADDSUB_SAT_EN: s=0x8000.
  - With ADDSUB_SAT_EN: s=0x7FFF.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → s=0xFFFE, cout=0, ovf=0.
  - Same ops with cin=1 → s=0xFFFD.
- Back-to-back stream of 8 ops (a=i, b=0x0100, cin=0, sub=0), with out_ready held low for 3 cycles after the first result:
  - Expected results 0x0100..0x0107, in order, none lost.
  - in_ready=0 exactly during the stall.
  - s held stable during the stall.
- Reset with 3 ops in flight → out_valid=0 and s=0 immediately. No result appears after release. The next op completes in 4 cycles.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Handshake bundle for pipelined_add_sub: operand side (in_*), result side (out_*).
interface pipelined_add_sub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor, CHUNK bits resolved per stage, valid/ready handshake.
// Optional build macro ADDSUB_SAT_EN: signed saturation of the result on overflow.
module pipelined_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_add_sub_if.slave bus
);
  localparam int STAGES  = WIDTH / CHUNK;
  localparam int LAST_LO = (STAGES - 1) * CHUNK;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a positive multiple of CHUNK");
  end

  logic adv;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;

  // Whole pipeline moves in lockstep; only a held result at the output can stall it.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.s        = s_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;

  // work_q carries resolved sum bits below the current slice and untouched a bits above;
  // b_q carries only the b_eff bits not yet consumed, so it narrows each stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int BW = WIDTH - LO;

    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [BW-1:0]    b_q, b_d;
    logic [CHUNK:0]   slice_sum;

    assign slice_sum = {1'b0, work_q[LO +: CHUNK]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};

    if (k == 0) begin : g_first
      always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        valid_d = valid_q;
        carry_d = carry_q;
        work_d  = work_q;
        b_d     = b_q;
        if (adv) begin
          valid_d = bus.in_valid;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          work_d  = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
        end
      end
    end else begin : g_next
      always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        work_d  = work_q;
        b_d     = b_q;
        if (adv) begin
          valid_d                    = g_stage[k-1].valid_q;
          carry_d                    = g_stage[k-1].slice_sum[CHUNK];
          work_d                     = g_stage[k-1].work_q;
          work_d[LO-CHUNK +: CHUNK]  = g_stage[k-1].slice_sum[CHUNK-1:0];
          b_d                        = g_stage[k-1].b_q[BW+CHUNK-1:CHUNK];
        end
      end
    end

    // NOTE: datapath flops are reset too, so a reset leaves no stale operand bits behind.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        work_q  <= '0;
        b_q     <= '0;
      end else begin
        // NOTE: non-blocking updates so every stage samples its neighbour's pre-edge value.
        valid_q <= valid_d;
        carry_q <= carry_d;
        work_q  <= work_d;
        b_q     <= b_d;
      end
    end
  end

  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_out;
  logic             a_msb;
  logic             carry_msb;
  logic             cout_calc;
  logic             ovf_calc;

  always_comb begin
    res_raw                      = g_stage[STAGES-1].work_q;
    res_raw[LAST_LO +: CHUNK]    = g_stage[STAGES-1].slice_sum[CHUNK-1:0];
    a_msb                        = g_stage[STAGES-1].work_q[WIDTH-1];
    // Sum MSB = a ^ b_eff ^ carry-in, so the carry into the MSB falls out by XOR.
    carry_msb = res_raw[WIDTH-1] ^ a_msb ^ g_stage[STAGES-1].b_q[CHUNK-1];
    cout_calc = g_stage[STAGES-1].slice_sum[CHUNK];
    ovf_calc  = carry_msb ^ cout_calc;
    res_out   = res_raw;
`ifdef ADDSUB_SAT_EN
    if (ovf_calc) begin
      res_out = {a_msb, {(WIDTH-1){~a_msb}}};
    end
`else
`endif

    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = g_stage[STAGES-1].valid_q;
      s_d         = res_out;
      cout_d      = cout_calc;
      ovf_d       = ovf_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(16)) bus ();
  pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] POS_OVF_S = 16'h7FFF;
  localparam logic [15:0] NEG_OVF_S = 16'h8000;
`else
  localparam logic [15:0] POS_OVF_S = 16'h8000;
  localparam logic [15:0] NEG_OVF_S = 16'h7FFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op into an empty pipeline and check latency and result.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, input logic [15:0] es,
                        input logic ecout, input logic eovf);
    int lat;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tcin;
    bus.sub       = tsub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_s"}, 32'(bus.s), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, recv, stall_left, cyc, seen;
    logic acc, take;
    logic [15:0] held_s;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_s", 32'(bus.s), 32'h0);
    check("rst_cout", 32'(bus.cout), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("add",        16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_S, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_bin",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run_op("sub_ok",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("ovf_neg",    16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OVF_S, 1'b1, 1'b1);
    run_op("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Stream of 8 ops with a 3-cycle stall right after the first result is taken.
    sent = 0;
    recv = 0;
    stall_left = 0;
    cyc = 0;
    held_s = '0;
    while (recv < 8 && cyc < 100) begin
      bus.in_valid  = (sent < 8);
      bus.a         = 16'(sent);
      bus.b         = 16'h0100;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'h0);
        check("stall_out_valid", 32'(bus.out_valid), 32'h1);
        if (stall_left == 3) held_s = bus.s;
        else check("stall_hold_s", 32'(bus.s), 32'(held_s));
      end else begin
        check("stream_in_ready", 32'(bus.in_ready), 32'h1);
      end
      acc  = bus.in_valid && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      if (take) begin
        check($sformatf("stream_s%0d", recv), 32'(bus.s), 32'h0100 + 32'(recv));
        check($sformatf("stream_c%0d", recv), 32'({bus.cout, bus.ovf}), 32'h0);
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (take) begin
        recv++;
        if (recv == 1) stall_left = 3;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_recv", 32'(recv), 32'd8);

    // Reset while stalled with three ops in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h0010 + 16'(i);
      bus.b        = 16'h0001;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_s", 32'(bus.s), 32'h0);
    check("mid_rst_flags", 32'({bus.cout, bus.ovf}), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("post_rst_stale", 32'(seen), 32'h0);
    @(posedge clk);
    #1;
    run_op("post_rst", 16'h0A0A, 16'h0505, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
